// File: rtl/rggen_apb_bridge.sv
// rggen_apb_bridge
//   Converts a single-outstanding valid/ready register bus request into an
//   APB3/APB4 transfer. One request is in flight at a time; the bus side sees
//   a one-cycle o_bus_ready pulse carrying the status and read data.
//
// Ports
//   i_clk, i_rst_n              clock, asynchronous active-low reset
//   i_bus_valid/access/address/write_data/strobe
//                               request side (held until o_bus_ready)
//   o_bus_ready/status/read_data
//                               response side (status 00 OKAY, 10 SLAVE_ERROR,
//                               11 timeout)
//   o_psel .. o_pwdata          APB requester outputs (o_pprot is the constant PPROT)
//   i_pready, i_prdata, i_pslverr
//                               APB completer inputs
//
// state  | meaning
// -------+-------------------------------------------------------------
// IDLE   | waiting for i_bus_valid; request fields captured on accept
// SETUP  | APB setup phase, psel=1 penable=0, always one cycle
// ACCESS | APB access phase, psel=1 penable=1, waits for pready/timeout
// RESP   | o_bus_ready pulse; new requests are not accepted here
module rggen_apb_bridge #(
  parameter int         ADDRESS_WIDTH  = 8,
  parameter int         BUS_WIDTH      = 32,
  parameter int         TIMEOUT_CYCLES = 0,
  parameter int         TIMEOUT_WIDTH  = 8,
  parameter logic [2:0] PPROT          = 3'b000
)(
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic                     i_bus_valid,
  input  logic [1:0]               i_bus_access,
  input  logic [ADDRESS_WIDTH-1:0] i_bus_address,
  input  logic [BUS_WIDTH-1:0]     i_bus_write_data,
  input  logic [BUS_WIDTH/8-1:0]   i_bus_strobe,
  output logic                     o_bus_ready,
  output logic [1:0]               o_bus_status,
  output logic [BUS_WIDTH-1:0]     o_bus_read_data,
  output logic                     o_psel,
  output logic                     o_penable,
  output logic [ADDRESS_WIDTH-1:0] o_paddr,
  output logic [2:0]               o_pprot,
  output logic                     o_pwrite,
  output logic [BUS_WIDTH/8-1:0]   o_pstrb,
  output logic [BUS_WIDTH-1:0]     o_pwdata,
  input  logic                     i_pready,
  input  logic [BUS_WIDTH-1:0]     i_prdata,
  input  logic                     i_pslverr
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    RESP   = 2'd3
  } state_t;

  state_t                   state;
  logic                     read_access;
  logic [TIMEOUT_WIDTH-1:0] timeout_count;
  logic [TIMEOUT_WIDTH-1:0] timeout_count_next;
  logic                     timeout_hit;

  assign o_pprot = PPROT;

  // The timeout fires in the ACCESS cycle whose increment would reach
  // TIMEOUT_CYCLES, so the bridge leaves after exactly TIMEOUT_CYCLES
  // unanswered ACCESS cycles. pready is checked first, so it wins a tie.
  assign timeout_count_next = timeout_count + 1'b1;
  assign timeout_hit = (TIMEOUT_CYCLES > 0) &&
                       (timeout_count_next == TIMEOUT_WIDTH'(TIMEOUT_CYCLES));

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state           <= IDLE;
      timeout_count   <= '0;
      read_access     <= 1'b0;
      o_bus_ready     <= 1'b0;
      o_bus_status    <= 2'b00;
      o_bus_read_data <= '0;
      o_psel          <= 1'b0;
      o_penable       <= 1'b0;
      o_paddr         <= '0;
      o_pwrite        <= 1'b0;
      o_pstrb         <= '0;
      o_pwdata        <= '0;
    end else begin
      o_bus_ready <= 1'b0;
      case (state)
        IDLE: begin
          if (i_bus_valid) begin
            o_paddr     <= i_bus_address;
            o_pwrite    <= i_bus_access[0];
            o_pstrb     <= i_bus_access[0] ? i_bus_strobe : '0;
            o_pwdata    <= i_bus_write_data;
            read_access <= (i_bus_access == 2'b10);
            o_psel      <= 1'b1;
            o_penable   <= 1'b0;
            state       <= SETUP;
          end
        end
        SETUP: begin
          o_penable     <= 1'b1;
          timeout_count <= '0;
          state         <= ACCESS;
        end
        ACCESS: begin
          if (i_pready) begin
            o_psel          <= 1'b0;
            o_penable       <= 1'b0;
            o_bus_status    <= i_pslverr ? 2'b10 : 2'b00;
            o_bus_read_data <= read_access ? i_prdata : '0;
            o_bus_ready     <= 1'b1;
            state           <= RESP;
          end else if (timeout_hit) begin
            o_psel          <= 1'b0;
            o_penable       <= 1'b0;
            o_bus_status    <= 2'b11;
            o_bus_read_data <= '0;
            o_bus_ready     <= 1'b1;
            state           <= RESP;
          end else begin
            timeout_count <= timeout_count_next;
          end
        end
        RESP: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rggen_apb_bridge.sv
module tb_rggen_apb_bridge;

  localparam int AW = 8;
  localparam int DW = 32;
  localparam int SW = DW / 8;

  logic          clk;
  logic          rst_n;
  logic          bus_valid;
  logic [1:0]    bus_access;
  logic [AW-1:0] bus_address;
  logic [DW-1:0] bus_write_data;
  logic [SW-1:0] bus_strobe;
  logic          bus_ready;
  logic [1:0]    bus_status;
  logic [DW-1:0] bus_read_data;
  logic          psel;
  logic          penable;
  logic [AW-1:0] paddr;
  logic [2:0]    pprot;
  logic          pwrite;
  logic [SW-1:0] pstrb;
  logic [DW-1:0] pwdata;
  logic          pready;
  logic [DW-1:0] prdata;
  logic          pslverr;

  int n_cmp = 0;
  int n_mis = 0;

  rggen_apb_bridge #(
    .ADDRESS_WIDTH  (AW),
    .BUS_WIDTH      (DW),
    .TIMEOUT_CYCLES (4),
    .TIMEOUT_WIDTH  (8),
    .PPROT          (3'b010)
  ) dut (
    .i_clk            (clk),
    .i_rst_n          (rst_n),
    .i_bus_valid      (bus_valid),
    .i_bus_access     (bus_access),
    .i_bus_address    (bus_address),
    .i_bus_write_data (bus_write_data),
    .i_bus_strobe     (bus_strobe),
    .o_bus_ready      (bus_ready),
    .o_bus_status     (bus_status),
    .o_bus_read_data  (bus_read_data),
    .o_psel           (psel),
    .o_penable        (penable),
    .o_paddr          (paddr),
    .o_pprot          (pprot),
    .o_pwrite         (pwrite),
    .o_pstrb          (pstrb),
    .o_pwdata         (pwdata),
    .i_pready         (pready),
    .i_prdata         (prdata),
    .i_pslverr        (pslverr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic request(input logic [1:0] acc, input logic [AW-1:0] addr,
                         input logic [DW-1:0] wdata, input logic [SW-1:0] strb);
    bus_valid      = 1'b1;
    bus_access     = acc;
    bus_address    = addr;
    bus_write_data = wdata;
    bus_strobe     = strb;
  endtask

  logic [12:0] rdy_seen;
  logic [12:0] sel_seen;

  initial begin
    rst_n          = 1'b0;
    bus_valid      = 1'b0;
    bus_access     = 2'b00;
    bus_address    = '0;
    bus_write_data = '0;
    bus_strobe     = '0;
    pready         = 1'b0;
    prdata         = '0;
    pslverr        = 1'b0;

    // reset state
    tick();
    tick();
    check("rst_psel", psel, 1'b0);
    check("rst_penable", penable, 1'b0);
    check("rst_ready", bus_ready, 1'b0);
    check("rst_status", bus_status, 2'b00);
    check("rst_rdata", bus_read_data, 32'h0);
    check("rst_paddr", paddr, 8'h00);
    check("rst_pstrb", pstrb, 4'h0);
    check("pprot_const", pprot, 3'b010);
    rst_n = 1'b1;
    tick();

    // zero-wait write
    request(2'b01, 8'h10, 32'hDEADBEEF, 4'hF);       // T0
    tick();                                          // T1 SETUP
    check("wr_t1_psel", psel, 1'b1);
    check("wr_t1_penable", penable, 1'b0);
    check("wr_t1_pwrite", pwrite, 1'b1);
    check("wr_t1_paddr", paddr, 8'h10);
    check("wr_t1_pwdata", pwdata, 32'hDEADBEEF);
    check("wr_t1_pstrb", pstrb, 4'hF);
    request(2'b10, 8'h55, 32'h0, 4'h0);
    bus_valid = 1'b0;
    tick();                                          // T2 ACCESS
    check("wr_t2_penable", penable, 1'b1);
    check("wr_t2_paddr_held", paddr, 8'h10);
    check("wr_t2_pwdata_held", pwdata, 32'hDEADBEEF);
    check("wr_t2_ready", bus_ready, 1'b0);
    pready = 1'b1;
    prdata = 32'h11112222;
    tick();                                          // T3 RESP
    pready = 1'b0;
    check("wr_t3_ready", bus_ready, 1'b1);
    check("wr_t3_status", bus_status, 2'b00);
    check("wr_t3_rdata", bus_read_data, 32'h0);
    check("wr_t3_psel", psel, 1'b0);
    tick();                                          // T4 IDLE
    check("wr_t4_ready", bus_ready, 1'b0);

    // read with two wait states
    request(2'b10, 8'h24, 32'hFFFFFFFF, 4'hF);       // T0
    tick();                                          // T1
    bus_valid = 1'b0;
    check("rd_t1_pwrite", pwrite, 1'b0);
    check("rd_t1_pstrb", pstrb, 4'h0);
    tick();                                          // T2 wait
    check("rd_t2_penable", penable, 1'b1);
    check("rd_t2_pstrb", pstrb, 4'h0);
    tick();                                          // T3 wait
    check("rd_t3_psel", psel, 1'b1);
    check("rd_t3_ready", bus_ready, 1'b0);
    tick();                                          // T4 ACCESS
    check("rd_t4_ready", bus_ready, 1'b0);
    pready = 1'b1;
    prdata = 32'h12345678;
    tick();                                          // T5 RESP
    pready = 1'b0;
    prdata = 32'h0;
    check("rd_t5_ready", bus_ready, 1'b1);
    check("rd_t5_rdata", bus_read_data, 32'h12345678);
    check("rd_t5_status", bus_status, 2'b00);
    tick();
    tick();
    check("rd_hold_rdata", bus_read_data, 32'h12345678);
    check("rd_hold_ready", bus_ready, 1'b0);

    // write with slave error
    request(2'b01, 8'h30, 32'h0BADF00D, 4'h3);
    tick();
    bus_valid = 1'b0;
    check("err_t1_pstrb", pstrb, 4'h3);
    tick();
    pready  = 1'b1;
    pslverr = 1'b1;
    prdata  = 32'hAAAAAAAA;
    tick();
    pready  = 1'b0;
    pslverr = 1'b0;
    check("err_ready", bus_ready, 1'b1);
    check("err_status", bus_status, 2'b10);
    check("err_rdata", bus_read_data, 32'h0);
    tick();
    check("err_hold_status", bus_status, 2'b10);

    // timeout: pready stuck low for 4 ACCESS cycles
    prdata = 32'h5A5A5A5A;
    request(2'b10, 8'h40, 32'h0, 4'hF);
    tick();                                          // T1
    bus_valid = 1'b0;
    tick();                                          // T2 ACCESS #1
    tick();                                          // T3 ACCESS #2
    tick();                                          // T4 ACCESS #3
    tick();                                          // T5 ACCESS #4
    check("to_t5_psel", psel, 1'b1);
    check("to_t5_ready", bus_ready, 1'b0);
    tick();                                          // T6 RESP
    check("to_t6_psel", psel, 1'b0);
    check("to_t6_penable", penable, 1'b0);
    check("to_t6_ready", bus_ready, 1'b1);
    check("to_t6_status", bus_status, 2'b11);
    check("to_t6_rdata", bus_read_data, 32'h0);
    tick();

    // pready arrives in the 4th ACCESS cycle: normal completion wins
    request(2'b10, 8'h44, 32'h0, 4'hF);
    tick();
    bus_valid = 1'b0;
    tick();
    tick();
    tick();
    tick();                                          // T5 ACCESS #4
    pready = 1'b1;
    prdata = 32'hCAFE0001;
    tick();                                          // T6 RESP
    pready = 1'b0;
    check("tie_ready", bus_ready, 1'b1);
    check("tie_status", bus_status, 2'b00);
    check("tie_rdata", bus_read_data, 32'hCAFE0001);
    tick();

    // back-to-back with valid held high and zero wait states
    pready   = 1'b1;
    rdy_seen = '0;
    sel_seen = '0;
    request(2'b01, 8'h50, 32'h01020304, 4'hF);       // T0
    for (int i = 1; i <= 12; i++) begin
      tick();
      rdy_seen[i] = bus_ready;
      sel_seen[i] = psel;
    end
    bus_valid = 1'b0;
    check("b2b_ready_pattern", rdy_seen, 13'b0_1000_1000_1000);
    check("b2b_psel_pattern", sel_seen, 13'b0_0110_0110_0110);
    tick();
    tick();
    pready = 1'b0;
    check("b2b_idle_psel", psel, 1'b0);

    // reset during ACCESS
    request(2'b01, 8'h60, 32'h77777777, 4'hF);
    tick();
    bus_valid = 1'b0;
    tick();                                          // ACCESS, pready low
    check("rst_mid_psel_before", psel, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    check("rst_mid_psel", psel, 1'b0);
    check("rst_mid_penable", penable, 1'b0);
    pready = 1'b1;
    tick();
    check("rst_mid_ready_a", bus_ready, 1'b0);
    tick();
    check("rst_mid_ready_b", bus_ready, 1'b0);
    pready = 1'b0;
    request(2'b01, 8'h64, 32'h89ABCDEF, 4'hC);
    #2;
    rst_n = 1'b1;
    tick();                                          // first edge after release
    bus_valid = 1'b0;
    check("rst_rel_psel", psel, 1'b1);
    check("rst_rel_paddr", paddr, 8'h64);
    check("rst_rel_ready", bus_ready, 1'b0);
    tick();
    pready = 1'b1;
    tick();
    pready = 1'b0;
    check("rst_rel_done_ready", bus_ready, 1'b1);
    check("rst_rel_done_status", bus_status, 2'b00);
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule

// File: doc/rggen_apb_bridge.md
RGGEN_APB_BRIDGE -- requirements
Module: rggen_apb_bridge

Interface
REQ-001 SHALL provide parameter ADDRESS_WIDTH, default 8: width of the bus and APB addresses.
REQ-002 SHALL provide parameter BUS_WIDTH, default 32: data width; legal values are 8, 16, 32 and 64.
REQ-003 SHALL provide parameter TIMEOUT_CYCLES, default 0: ACCESS-phase cycle limit; 0 disables the timeout.
REQ-004 SHALL provide parameter TIMEOUT_WIDTH, default 8: counter width; TIMEOUT_CYCLES SHALL be less than 2**TIMEOUT_WIDTH.
REQ-005 SHALL provide parameter PPROT, default 3'b000: constant value driven on o_pprot.
REQ-006 SHALL have ports, each listed as name, direction, width, meaning:
- i_clk, in, 1, single clock; all logic rising-edge.
- i_rst_n, in, 1, reset; asynchronous, active-low.
- i_bus_valid, in, 1, request valid; held until o_bus_ready.
- i_bus_access, in, 2, access type; 2'b10 is read; bit0=1 is write.
- i_bus_address, in, ADDRESS_WIDTH, byte address.
- i_bus_write_data, in, BUS_WIDTH, write data.
- i_bus_strobe, in, BUS_WIDTH/8, byte strobes.
- o_bus_ready, out, 1, one-cycle completion pulse.
- o_bus_status, out, 2, 00 OKAY, 10 SLAVE_ERROR, 11 DECODE_ERROR (timeout).
- o_bus_read_data, out, BUS_WIDTH, read response.
- o_psel, out, 1, APB select.
- o_penable, out, 1, APB enable.
- o_paddr, out, ADDRESS_WIDTH, APB address.
- o_pprot, out, 3, APB protection.
- o_pwrite, out, 1, APB direction.
- o_pstrb, out, BUS_WIDTH/8, APB strobes.
- o_pwdata, out, BUS_WIDTH, APB write data.
- i_pready, in, 1, APB ready.
- i_prdata, in, BUS_WIDTH, APB read data.
- i_pslverr, in, 1, APB slave error.

Function
REQ-007 SHALL implement a four-state FSM: IDLE, SETUP, ACCESS and RESP; all outputs are driven from registers except o_pprot, which is the constant PPROT.
REQ-008 IDLE: when i_bus_valid=1, SHALL capture the request fields into registers and go to SETUP; otherwise SHALL stay in IDLE.
REQ-009 SETUP: SHALL drive o_psel=1 and o_penable=0 for exactly one cycle, then go to ACCESS.
REQ-010 ACCESS: SHALL drive o_psel=1 and o_penable=1, and SHALL hold o_paddr, o_pwrite, o_pstrb and o_pwdata constant from SETUP through the last ACCESS cycle.
REQ-011 o_pwrite SHALL equal captured i_bus_access[0]; o_pstrb SHALL equal captured strobes for writes and SHALL be all-zero for reads.
REQ-012 ACCESS completion on i_pready=1: SHALL register o_bus_status (i_pslverr ? 2'b10 : 2'b00), register o_bus_read_data (i_prdata for reads, zero for writes), drop psel/penable on the next edge and go to RESP.
REQ-013 RESP: SHALL drive o_bus_ready=1 for exactly one cycle, then go to IDLE.
REQ-014 Latency: the accept cycle is T0; with zero APB wait states o_bus_ready=1 at T3; each APB wait state adds one cycle.
REQ-015 A request still valid in the RESP cycle SHALL NOT be accepted; the earliest next accept is the following IDLE cycle, giving back-to-back throughput of one transfer per 4 cycles.
REQ-016 Timeout, TIMEOUT_CYCLES>0: a counter SHALL clear on entering ACCESS and increment each ACCESS cycle with i_pready=0.
REQ-017 When the counter equals TIMEOUT_CYCLES with i_pready=0, the FSM SHALL abort to RESP with status 2'b11 and read data zero, and SHALL deassert psel/penable.
REQ-018 If i_pready=1 arrives in the same cycle the timeout would fire, i_pready SHALL win and a normal completion SHALL occur.
REQ-019 With TIMEOUT_CYCLES=0 the bridge SHALL wait indefinitely for i_pready.
REQ-020 o_bus_status and o_bus_read_data SHALL hold their last values outside RESP.
REQ-021 Request fields that change after T0 SHALL be ignored until the next accept.

Reset
REQ-022 While i_rst_n=0, regardless of clock, SHALL force: FSM=IDLE, counter=0, all registered outputs=0.
REQ-023 Reset asserted mid-transfer SHALL drop o_psel and o_penable immediately, issue no o_bus_ready pulse for the aborted request, and accept a new request on the first edge after release.

Verification
REQ-024 Zero-wait write: addr 0x10, data 0xDEADBEEF, strb 4'hF -> SETUP at T1, ACCESS at T2, o_bus_ready at T3, status 00.
REQ-025 Read with i_pready low for 2 ACCESS cycles and i_prdata=0x12345678 -> o_bus_ready at T5, read_data 0x12345678, o_pstrb=0 throughout.
REQ-026 Write with i_pslverr=1 at completion -> status 10, read_data 0.
REQ-027 TIMEOUT_CYCLES=4 with i_pready stuck at 0 -> psel drops after 4 ACCESS cycles, status 11; a second run with i_pready=1 in the 4th ACCESS cycle -> status 00.
REQ-028 Back-to-back with i_bus_valid held high -> o_bus_ready pulses spaced exactly 4 cycles apart; no accept occurs in a RESP cycle.
REQ-029 i_rst_n pulsed low during ACCESS -> psel=0 asynchronously, no ready pulse, a new transfer completes normally after release.
